// File: rtl/neuron_pkg.sv
// neuron_pkg: shared definitions for the multi-lane neuron MAC.
//   neuron_state_e : FSM encoding (IDLE -> CALC -> DONE)
//   log2_ceil      : ceiling log2, sizes the count and index fields
//   acc_width      : signed accumulator width for a given neuron geometry
//   beats          : number of CALC cycles needed for n inputs on a given lane count
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } neuron_state_e;

    function automatic int log2_ceil(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // One bit of headroom per doubling of the input count, plus the
    // product width and a sign guard bit.
    function automatic int acc_width(input int neuron_num, input int weight_w,
                                     input int act_w);
        return log2_ceil(neuron_num) + weight_w + act_w + 1;
    endfunction

    function automatic int beats(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

endpackage

// File: rtl/neuron_parallel_lane_mac.sv
// neuron_lane_mac: combinational slice of the neuron MAC.
// Selects LANES consecutive activation/weight pairs starting at element
// 'base', zeroes every lane whose element index is at or beyond 'count',
// multiplies each pair as signed values and sums the lane products.
//   inputs   in  packed activations, element i at [i*AW +: AW]
//   weights  in  packed weights, element i at [i*WW +: WW]
//   base     in  index of the first element handled this beat
//   count    in  active input count (already clamped to NEURON_NUM)
//   lane_sum out signed sum of the unmasked lane products, ACC_WIDTH wide
module neuron_lane_mac #(
    parameter int NEURON_NUM        = 5,
    parameter int LANES             = 2,
    parameter int ACTIVATION_WIDTH  = 9,
    parameter int WEIGHT_CELL_WIDTH = 16,
    parameter int ACC_WIDTH         = 29,
    parameter int IDX_W             = 4,
    parameter int NUM_W             = 4
) (
    input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]  inputs,
    input  logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] weights,
    input  logic [IDX_W-1:0]                        base,
    input  logic [NUM_W-1:0]                        count,
    output logic signed [ACC_WIDTH-1:0]             lane_sum
);

    localparam int AW = ACTIVATION_WIDTH;
    localparam int WW = WEIGHT_CELL_WIDTH;

    always_comb begin
        logic [AW-1:0]               act_sel;
        logic [WW-1:0]               wt_sel;
        logic signed [ACC_WIDTH-1:0] act_ext;
        logic signed [ACC_WIDTH-1:0] wt_ext;
        lane_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            act_sel = '0;
            wt_sel  = '0;
            // A lane pointing past the active count keeps zero operands, so
            // its product drops out of the sum.
            for (int i = 0; i < NEURON_NUM; i++) begin
                if ((int'(base) + l == i) && (i < int'(count))) begin
                    act_sel = inputs[i*AW +: AW];
                    wt_sel  = weights[i*WW +: WW];
                end
            end
            act_ext  = $signed({{(ACC_WIDTH-AW){act_sel[AW-1]}}, act_sel});
            wt_ext   = $signed({{(ACC_WIDTH-WW){wt_sel[WW-1]}}, wt_sel});
            lane_sum = lane_sum + act_ext * wt_ext;
        end
    end

endmodule

// File: rtl/neuron_parallel.sv
// neuron_parallel: multi-lane neuron multiply-accumulate.
// Captures an activation vector, a weight vector and an active input count
// on three independent channels, accumulates LANES signed products per
// cycle, and presents the fixed-point sum with an overflow flag.
//
// Ports:
//   clk, rst                        clock (rising edge), async active-low reset
//   input_number/_valid/_ready      active input count n (clamped to NEURON_NUM)
//   inputs/_valid/_ready            packed activations
//   weights/_valid/_ready           packed weights
//   neuron_sum, overflow            result slice and overflow flag
//   neuron_sum_valid/_ready         result channel
//   state_dbg                       current FSM state
//
// Handshake rules (all channels): a transfer happens on a rising edge where
// valid and ready are both high. Each operand channel owns a buffer and a
// set flag; ready is simply !set, so a channel whose flag is set ignores
// valid. neuron_sum_valid depends only on the state register, never on
// neuron_sum_ready, and once high it stays high with a stable payload until
// the handshake.
//
// Build option: define NEURON_SATURATE_EN to clamp neuron_sum to the largest
// positive / most negative value when overflow is flagged; otherwise
// neuron_sum is the wrapped slice of the accumulator.
module neuron_parallel
    import neuron_pkg::*;
#(
    parameter int NEURON_NUM          = 5,
    parameter int LANES               = 2,
    parameter int NEURON_OUTPUT_WIDTH = 10,
    parameter int ACTIVATION_WIDTH    = 9,
    parameter int WEIGHT_CELL_WIDTH   = 16,
    parameter int FRACTION            = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [log2_ceil(NEURON_NUM):0]          input_number,
    input  logic                                    input_number_valid,
    output logic                                    input_number_ready,
    input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]  inputs,
    input  logic                                    inputs_valid,
    output logic                                    inputs_ready,
    input  logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] weights,
    input  logic                                    weights_valid,
    output logic                                    weights_ready,
    output logic [NEURON_OUTPUT_WIDTH-1:0]          neuron_sum,
    output logic                                    overflow,
    output logic                                    neuron_sum_valid,
    input  logic                                    neuron_sum_ready,
    output neuron_state_e                           state_dbg
);

    localparam int NUM_W     = log2_ceil(NEURON_NUM) + 1;
    localparam int ACC_WIDTH = acc_width(NEURON_NUM, WEIGHT_CELL_WIDTH, ACTIVATION_WIDTH);
    localparam int IDX_W     = log2_ceil(NEURON_NUM + LANES) + 1;
    localparam int SUM_HI    = NEURON_OUTPUT_WIDTH + FRACTION - 1;
    localparam int HI_W      = ACC_WIDTH - SUM_HI;
    localparam int OW        = NEURON_OUTPUT_WIDTH;

    neuron_state_e state, state_next;

    logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]  in_buf;
    logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] wt_buf;
    logic [NUM_W-1:0]                        num_buf;
    logic                                    in_set, wt_set, num_set;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] lane_sum;
    logic [IDX_W-1:0]            base_q;     // first element index of the current beat

    logic [NUM_W-1:0] n_clamped;
    logic             all_set;
    logic             last_beat;
    logic             clear_flags;
    logic             can_capture;

    assign n_clamped = (num_buf > NUM_W'(NEURON_NUM)) ? NUM_W'(NEURON_NUM) : num_buf;
    assign all_set   = in_set && wt_set && num_set;
    // The current beat is the last one once it covers element n-1.
    assign last_beat = (int'(base_q) + LANES >= int'(n_clamped));
    // Flags drop on the edge that enters DONE, freeing the channels for the
    // next operands while the result waits for its consumer.
    assign clear_flags = ((state == ST_CALC) && last_beat) ||
                         ((state == ST_IDLE) && all_set && (n_clamped == '0));
    assign can_capture = (state != ST_CALC);

    neuron_lane_mac #(
        .NEURON_NUM        (NEURON_NUM),
        .LANES             (LANES),
        .ACTIVATION_WIDTH  (ACTIVATION_WIDTH),
        .WEIGHT_CELL_WIDTH (WEIGHT_CELL_WIDTH),
        .ACC_WIDTH         (ACC_WIDTH),
        .IDX_W             (IDX_W),
        .NUM_W             (NUM_W)
    ) u_lane_mac (
        .inputs   (in_buf),
        .weights  (wt_buf),
        .base     (base_q),
        .count    (n_clamped),
        .lane_sum (lane_sum)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (all_set) state_next = (n_clamped == '0) ? ST_DONE : ST_CALC;
            ST_CALC: if (last_beat) state_next = ST_DONE;
            ST_DONE: if (neuron_sum_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        neuron_sum_valid   = (state == ST_DONE);
        input_number_ready = !num_set;
        inputs_ready       = !in_set;
        weights_ready      = !wt_set;
        state_dbg          = state;
    end

    // Operand channels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_buf  <= '0;
            wt_buf  <= '0;
            num_buf <= '0;
            in_set  <= 1'b0;
            wt_set  <= 1'b0;
            num_set <= 1'b0;
        end else if (clear_flags) begin
            in_set  <= 1'b0;
            wt_set  <= 1'b0;
            num_set <= 1'b0;
        end else if (can_capture) begin
            if (inputs_valid && !in_set) begin
                in_buf <= inputs;
                in_set <= 1'b1;
            end
            if (weights_valid && !wt_set) begin
                wt_buf <= weights;
                wt_set <= 1'b1;
            end
            if (input_number_valid && !num_set) begin
                num_buf <= input_number;
                num_set <= 1'b1;
            end
        end
    end

    // Accumulator and beat pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            base_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    acc    <= '0;
                    base_q <= '0;
                end
                ST_CALC: begin
                    acc    <= acc + lane_sum;
                    base_q <= base_q + IDX_W'(LANES);
                end
                ST_DONE: if (neuron_sum_ready) acc <= '0;
                default: begin
                    acc    <= '0;
                    base_q <= '0;
                end
            endcase
        end
    end

    // Result formatting: the bits above the output slice (plus its sign bit)
    // must all agree for the result to be representable.
    logic [OW-1:0]   sum_slice;
    logic [HI_W-1:0] hi_bits;

    always_comb begin
        sum_slice = acc[SUM_HI:FRACTION];
        hi_bits   = acc[ACC_WIDTH-1:SUM_HI];
        overflow  = !((&hi_bits) || !(|hi_bits));
`ifdef NEURON_SATURATE_EN
        if (overflow)
            neuron_sum = acc[ACC_WIDTH-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        else
            neuron_sum = sum_slice;
`else
        neuron_sum = sum_slice;
`endif
    end

endmodule
